game_render: RTL and testbench
==============================

# game_render

Pixel-generation back end for the brick game: it reads the brick array, ball position, paddle position and game flags that the ball/paddle logic produces, and turns them into an 800x600 SVGA raster with sync. It runs continuously from the 50 MHz pixel clock. To avoid tearing, it snapshots all game inputs once per frame. Its outputs drive the VGA DAC pins directly.

## Interface
- radius, 4, ball radius in pixels
- paddle_length, 60, paddle half-width in pixels
- clk  in  1  50 MHz pixel clock
- rst  in  1  asynchronous, active-high reset
- brick_flat  in  128  brick i strength (0..3) in bits [2i+1:2i], i = row*8+col
- x  in  11  ball centre x
- y  in  10  ball centre y
- x_paddle  in  11  paddle centre x
- state  in  3  game state (1 load, 2 wait, 3 run)
- dead  in  1  ball lost flag
- win  in  1  all bricks cleared flag
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- de  out  1  visible-area data enable
- rgb  out  12  pixel colour, R[11:8] G[7:4] B[3:0]
- frame_tick  out  1  one-cycle pulse at start of vertical blank

## Operation
- **Raster counters**
  - hcnt counts 0..1039: visible 0..799, front porch 800..855, sync 856..975, back porch 976..1039.
  - vcnt counts 0..665, advancing when hcnt wraps: visible 0..599, front porch 600..636, sync 637..642, back porch 643..665.
  - Both wrap to 0 after their last value.
- **Snapshot**
  - On the cycle where hcnt==0 and vcnt==600, all inputs are latched into shadow registers.
  - frame_tick pulses on that same cycle.
  - All drawing uses the shadow copies only. Input changes mid-frame are invisible until the next frame.
- **Brick grid**
  - 8 columns of 100 px and 8 rows of 30 px, covering y 0..239.
  - col = hcnt/100, row = vcnt/30, both computed with incremental sub-counters. No dividers.
  - Pixels in the last column or last row of a cell (sub-counter 99 or 29) form a black gap.
- **Layer priority, highest first:**
  1. Ball: drawn when shadow state is 2 or 3 and (hcnt-x)^2+(vcnt-y)^2 <= radius^2, using signed 12-bit differences. Colour 0xFFF.
  2. Paddle: drawn when 571 <= vcnt <= 580 and x_paddle-paddle_length <= hcnt <= x_paddle+paddle_length. Compare in 12-bit signed; the lower bound saturates at 0. Colour 0x0AF.
  3. Brick: drawn for a non-gap pixel with strength s != 0. s=1 gives 0x0F0, s=2 gives 0xFF0, s=3 gives 0xF00.
  4. Background: 0x800 if dead, else 0x080 if win, else 0x000. Dead takes precedence over win.
- Outside the visible area, rgb is 0.

## Timing
- **Two-stage pipeline.**
  - Stage 1 registers the region hits and the brick strength.
  - Stage 2 registers rgb.
- hsync, vsync and de are delayed through two matching registers, so rgb for counter value (h,v) appears exactly 2 cycles after the counters held (h,v), aligned with its de.
- **Reset values.**
  - hcnt = vcnt = 0 and all sub-counters = 0.
  - hsync, vsync, de, frame_tick = 0.
  - rgb = 0.
  - Shadow registers = 0; shadow state = 0 means the ball is hidden.
- Reset asserted mid-frame clears everything within the same cycle (asynchronous). After release, counting restarts at (0,0) on the first clock edge.
- Frame length is 1040*666 = 692640 cycles.
- The hsync high time is 120 cycles per line. The vsync high time is 6 lines = 6240 cycles.

## Test plan
- **Reset and raster timing.** Hold rst for 5 cycles, then release.
  - rgb=0 and sync=0 during reset.
  - First hsync rise 858 cycles after release (856 plus 2 pipeline cycles).
  - Successive frame_tick pulses exactly 692640 cycles apart.
- **Brick colours and gap.** brick_flat with brick 0=1, brick 9=3, others 0.
  - Pixel (50,15) = 0x0F0.
  - Pixel (150,45) = 0xF00.
  - Pixels (99,15) and (50,29) = 0x000.
- **Ball overlay and snapshot.** state=3, x=400, y=300, radius 4.
  - Pixels (400,296) and (404,300) = 0xFFF; pixel (404,304) = background.
  - Change x to 500 during visible line 100: the current frame still shows the ball at 400; the next frame shows it at 500.
- **Paddle clipping.** x_paddle=20, paddle_length 60.
  - Pixels (0,575) and (80,575) = 0x0AF; pixel (81,575) = 0x000.
  - Ball at (20,575) with state=2: pixel (20,575) = 0xFFF, because the ball wins priority.
- **Game flags.** dead=1 and win=1 together: background 0x800. win=1 alone: 0x080. Pixels in blanking are 0 in both cases.
- **Hidden ball.** state=1 with x=400, y=300: pixel (400,300) = background.

Source files
------------

// File: rtl/game_render.sv
// game_render: SVGA 800x600 raster generator for the brick game.
// Game inputs are snapshotted once per frame; two-stage pixel pipeline.
module game_render #(
  parameter int radius        = 4,
  parameter int paddle_length = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] brick_flat,
  input  logic [10:0]  x,
  input  logic [9:0]   y,
  input  logic [10:0]  x_paddle,
  input  logic [2:0]   state,
  input  logic         dead,
  input  logic         win,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic [11:0]  rgb,
  output logic         frame_tick
);

  localparam logic [24:0] R2   = 25'(radius * radius);
  localparam logic [12:0] PLEN = 13'(paddle_length);

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [6:0]  hsub_q, hsub_d;
  logic [3:0]  col_q, col_d;
  logic [4:0]  vsub_q, vsub_d;
  logic [4:0]  row_q, row_d;
  logic        h_last, v_last, snap;

  logic [127:0] brick_q;
  logic [10:0]  xs_q, xp_q;
  logic [9:0]   ys_q;
  logic [2:0]   st_q;
  logic         dead_q, win_q;

  logic        ball1_q, pad1_q, de1_q, hs1_q, vs1_q;
  logic [1:0]  str1_q;
  logic        ball_c, pad_c, vis_c, hs_c, vs_c;
  logic [1:0]  str_c;
  logic        hs2_q, vs2_q, de2_q;
  logic [11:0] rgb_q, rgb_d;

  logic signed [11:0] dx, dy;
  logic [23:0] dxx, dyy;
  logic [24:0] d2;
  logic [12:0] plo, phi, h13;
  logic [5:0]  idx;
  logic        in_grid;

  always_comb begin
    h_last = (hcnt_q == 11'd1039);
    v_last = (vcnt_q == 10'd665);
    hcnt_d = h_last ? 11'd0 : hcnt_q + 11'd1;
    hsub_d = (h_last || hsub_q == 7'd99) ? 7'd0 : hsub_q + 7'd1;
    col_d  = col_q;
    if (h_last) col_d = 4'd0;
    else if (hsub_q == 7'd99) col_d = col_q + 4'd1;
    vcnt_d = vcnt_q;
    vsub_d = vsub_q;
    row_d  = row_q;
    if (h_last) begin
      if (v_last) begin
        vcnt_d = 10'd0;
        vsub_d = 5'd0;
        row_d  = 5'd0;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
        if (vsub_q == 5'd29) begin
          vsub_d = 5'd0;
          row_d  = row_q + 5'd1;
        end else begin
          vsub_d = vsub_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hsub_q <= '0;
      col_q  <= '0;
      vsub_q <= '0;
      row_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hsub_q <= hsub_d;
      col_q  <= col_d;
      vsub_q <= vsub_d;
      row_q  <= row_d;
    end
  end

  // Latch the game state at the start of vertical blank.
  assign snap       = (hcnt_q == 11'd0) && (vcnt_q == 10'd600);
  assign frame_tick = snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brick_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      xp_q    <= '0;
      st_q    <= '0;
      dead_q  <= 1'b0;
      win_q   <= 1'b0;
    end else if (snap) begin
      brick_q <= brick_flat;
      xs_q    <= x;
      ys_q    <= y;
      xp_q    <= x_paddle;
      st_q    <= state;
      dead_q  <= dead;
      win_q   <= win;
    end
  end

  always_comb begin
    dx  = $signed({1'b0, hcnt_q}) - $signed({1'b0, xs_q});
    dy  = $signed({2'b0, vcnt_q}) - $signed({2'b0, ys_q});
    dxx = 24'(dx * dx);
    dyy = 24'(dy * dy);
    d2  = {1'b0, dxx} + {1'b0, dyy};
    ball_c = ((st_q == 3'd2) || (st_q == 3'd3)) && (d2 <= R2);

    h13 = {2'b0, hcnt_q};
    plo = ({2'b0, xp_q} < PLEN) ? 13'd0 : {2'b0, xp_q} - PLEN;
    phi = {2'b0, xp_q} + PLEN;
    pad_c = (vcnt_q >= 10'd571) && (vcnt_q <= 10'd580) &&
            (h13 >= plo) && (h13 <= phi);

    in_grid = (row_q < 5'd8) && (col_q < 4'd8) &&
              (hsub_q != 7'd99) && (vsub_q != 5'd29);
    idx   = {row_q[2:0], col_q[2:0]};
    str_c = in_grid ? brick_q[{idx, 1'b0} +: 2] : 2'd0;

    vis_c = (hcnt_q < 11'd800) && (vcnt_q < 10'd600);
    hs_c  = (hcnt_q >= 11'd856) && (hcnt_q <= 11'd975);
    vs_c  = (vcnt_q >= 10'd637) && (vcnt_q <= 10'd642);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball1_q <= 1'b0;
      pad1_q  <= 1'b0;
      str1_q  <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
    end else begin
      ball1_q <= ball_c;
      pad1_q  <= pad_c;
      str1_q  <= str_c;
      de1_q   <= vis_c;
      hs1_q   <= hs_c;
      vs1_q   <= vs_c;
    end
  end

  always_comb begin
    rgb_d = 12'h000;
    if (de1_q) begin
      if (ball1_q)              rgb_d = 12'hFFF;
      else if (pad1_q)          rgb_d = 12'h0AF;
      else if (str1_q == 2'd1)  rgb_d = 12'h0F0;
      else if (str1_q == 2'd2)  rgb_d = 12'hFF0;
      else if (str1_q == 2'd3)  rgb_d = 12'hF00;
      else if (dead_q)          rgb_d = 12'h800;
      else if (win_q)           rgb_d = 12'h080;
      else                      rgb_d = 12'h000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign rgb   = rgb_q;
  assign de    = de2_q;
  assign hsync = hs2_q;
  assign vsync = vs2_q;

endmodule

// File: tb/tb_game_render.sv
// tb_game_render: directed pixel vectors across five frames,
// plus sync/frame_tick timing and asynchronous reset checks.
module tb_game_render;

  localparam longint FR = 64'd692640;
  localparam longint SNAP = 64'd624000;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] brick_flat;
  logic [10:0]  x;
  logic [9:0]   y;
  logic [10:0]  x_paddle;
  logic [2:0]   state;
  logic         dead, win;
  logic         hsync, vsync, de, frame_tick;
  logic [11:0]  rgb;

  game_render #(.radius(4), .paddle_length(60)) dut (
    .clk(clk), .rst(rst), .brick_flat(brick_flat),
    .x(x), .y(y), .x_paddle(x_paddle), .state(state),
    .dead(dead), .win(win), .hsync(hsync), .vsync(vsync),
    .de(de), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          fr;
    int          h;
    int          v;
    logic [11:0] exp;
    int          cfg;
  } vec_t;

  vec_t   vt[$];
  int     nvec = 0;
  int     nmis = 0;
  longint cyc  = 0;
  int     ticks = 0;
  logic   hs_p = 1'b0, vs_p = 1'b0;
  int     hs_n = 0, vs_n = 0;
  longint hs_rise = 0, vs_rise = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic apply_cfg(input int c);
    case (c)
      1: begin
        brick_flat = '0;
        brick_flat[1:0]   = 2'd1;
        brick_flat[19:18] = 2'd3;
        state = 3'd3; x = 11'd400; y = 10'd300;
        x_paddle = 11'd20; dead = 1'b0; win = 1'b0;
      end
      2: begin
        x = 11'd500; dead = 1'b1; win = 1'b1;
      end
      3: begin
        state = 3'd2; x = 11'd20; y = 10'd575;
        dead = 1'b0; win = 1'b1;
      end
      4: begin
        state = 3'd1; x = 11'd400; y = 10'd300;
        dead = 1'b0; win = 1'b0;
      end
      default: ;
    endcase
  endtask

  // Advance to edge count t, watching sync and frame_tick each cycle.
  task automatic goto(input longint t);
    if (t <= cyc) chk("vector_order", cyc, t);
    while (cyc < t) begin
      @(posedge clk);
      cyc++;
      #1;
      if (frame_tick) begin
        chk("frame_tick_cycle", cyc, longint'(ticks) * FR + SNAP);
        ticks++;
      end
      if (hsync && !hs_p) begin
        if (hs_n == 0) chk("hsync_first_rise", cyc, 858);
        hs_rise = cyc;
      end
      if (!hsync && hs_p) begin
        if (hs_n == 0) chk("hsync_width", cyc - hs_rise, 120);
        hs_n++;
      end
      if (vsync && !vs_p) begin
        if (vs_n == 0) chk("vsync_first_rise", cyc, 64'd662482);
        vs_rise = cyc;
      end
      if (!vsync && vs_p) begin
        if (vs_n == 0) chk("vsync_width", cyc - vs_rise, 6240);
        vs_n++;
      end
      hs_p = hsync;
      vs_p = vsync;
    end
  endtask

  initial begin
    vt.push_back('{0,  50,  15, 12'h000, 0});
    vt.push_back('{0, 400, 300, 12'h000, 0});
    vt.push_back('{1,  50,  15, 12'h0F0, 0});
    vt.push_back('{1,  99,  15, 12'h000, 0});
    vt.push_back('{1,  50,  29, 12'h000, 0});
    vt.push_back('{1, 150,  45, 12'hF00, 0});
    vt.push_back('{1,   0, 100, 12'h000, 2});
    vt.push_back('{1, 400, 296, 12'hFFF, 0});
    vt.push_back('{1, 404, 300, 12'hFFF, 0});
    vt.push_back('{1, 500, 300, 12'h000, 0});
    vt.push_back('{1, 404, 304, 12'h000, 0});
    vt.push_back('{1,   0, 575, 12'h0AF, 0});
    vt.push_back('{1,  80, 575, 12'h0AF, 0});
    vt.push_back('{1,  81, 575, 12'h000, 0});
    vt.push_back('{2,  50,  15, 12'h0F0, 0});
    vt.push_back('{2, 850,  15, 12'h000, 0});
    vt.push_back('{2,   0, 100, 12'h800, 3});
    vt.push_back('{2, 400, 300, 12'h800, 0});
    vt.push_back('{2, 500, 300, 12'hFFF, 0});
    vt.push_back('{2, 900, 300, 12'h000, 0});
    vt.push_back('{2,   0, 575, 12'h0AF, 0});
    vt.push_back('{2, 100, 620, 12'h000, 0});
    vt.push_back('{3,   0, 100, 12'h080, 4});
    vt.push_back('{3, 300, 300, 12'h080, 0});
    vt.push_back('{3,   0, 575, 12'h0AF, 0});
    vt.push_back('{3,  20, 575, 12'hFFF, 0});
    vt.push_back('{3,  81, 575, 12'h080, 0});
    vt.push_back('{3, 900, 575, 12'h000, 0});
    vt.push_back('{4,  50,  15, 12'h0F0, 0});
    vt.push_back('{4, 400, 296, 12'h000, 0});
    vt.push_back('{4, 400, 300, 12'h000, 0});
    vt.push_back('{4,   0, 571, 12'h0AF, 0});

    rst = 1'b1;
    apply_cfg(1);
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rgb", rgb, 0);
    chk("reset_hsync", hsync, 0);
    chk("reset_vsync", vsync, 0);
    chk("reset_de", de, 0);
    chk("reset_frame_tick", frame_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    foreach (vt[i]) begin
      goto(longint'(vt[i].fr) * FR + longint'(vt[i].v) * 1040
           + longint'(vt[i].h) + 2);
      chk($sformatf("pix%0d_f%0d_(%0d,%0d)", i, vt[i].fr, vt[i].h,
                    vt[i].v), rgb, vt[i].exp);
      chk($sformatf("de%0d", i), de,
          (vt[i].h < 800 && vt[i].v < 600) ? 1 : 0);
      apply_cfg(vt[i].cfg);
    end
    chk("frame_tick_count", ticks, 4);

    #3 rst = 1'b1;
    #1;
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_de", de, 0);
    chk("async_rst_tick", frame_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_de_edge1", de, 0);
    @(posedge clk);
    #1;
    chk("restart_de_edge2", de, 1);
    chk("restart_rgb_edge2", rgb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
